// File: rtl/dsp_timing.sv
// dsp_timing: 640x480@60 video timing generator for the character display.
// Ports:
//   clk, reset (async, active-high)
//   pixclk    pixel enable (every second clk)
//   char_col  hcnt[9:3]   char_row vcnt[8:4]
//   pix_col   hcnt[2:0]   pix_row  vcnt[3:0]
//   blank     1 = visible, delayed PIPE_DELAY ticks
//   hsync     active-low, delayed PIPE_DELAY ticks
//   vsync     active-low, delayed PIPE_DELAY ticks
//   blink     toggles every BLINK_FRAMES frames
module dsp_timing #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned PIPE_DELAY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixclk,
  output logic [6:0] char_col,
  output logic [4:0] char_row,
  output logic [2:0] pix_col,
  output logic [3:0] pix_row,
  output logic       blank,
  output logic       hsync,
  output logic       vsync,
  output logic       blink
);

  localparam int unsigned HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HT_M1   = 10'(HT - 1);
  localparam logic [9:0] VT_M1   = 10'(VT - 1);
  localparam logic [9:0] HVIS    = 10'(H_VISIBLE);
  localparam logic [9:0] VVIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // A zero delay still needs one output register, so keep at least one stage.
  localparam int STAGES = (PIPE_DELAY == 0) ? 1 : int'(PIPE_DELAY);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic              div_q, div_d;
  logic [9:0]        hcnt_q, hcnt_d;
  logic [9:0]        vcnt_q, vcnt_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              blink_q, blink_d;
  logic [STAGES-1:0] blank_sh_q, blank_sh_d;
  logic [STAGES-1:0] hs_sh_q, hs_sh_d;
  logic [STAGES-1:0] vs_sh_q, vs_sh_d;

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic frame_end;
  logic blank_raw;
  logic hs_raw;
  logic vs_raw;

  // A tick is a clk edge seen while pixclk is high.
  assign tick      = div_q;
  assign h_wrap    = (hcnt_q == HT_M1);
  assign v_wrap    = (vcnt_q == VT_M1);
  assign frame_end = tick & h_wrap & v_wrap;

  assign blank_raw = (hcnt_q < HVIS) & (vcnt_q < VVIS);
  assign hs_raw    = ~((hcnt_q >= HS_BEG) & (hcnt_q < HS_END));
  assign vs_raw    = ~((vcnt_q >= VS_BEG) & (vcnt_q < VS_END));

  always_comb begin
    div_d = ~div_q;
  end

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (h_wrap) begin
        hcnt_d = '0;
        if (v_wrap) begin
          vcnt_d = '0;
        end else begin
          vcnt_d = vcnt_q + 10'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (frame_end) begin
      if (fcnt_q == F_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    blank_sh_d = blank_sh_q;
    hs_sh_d    = hs_sh_q;
    vs_sh_d    = vs_sh_q;
    if (tick) begin
      blank_sh_d[0] = blank_raw;
      hs_sh_d[0]    = hs_raw;
      vs_sh_d[0]    = vs_raw;
      for (int i = 1; i < STAGES; i++) begin
        blank_sh_d[i] = blank_sh_q[i-1];
        hs_sh_d[i]    = hs_sh_q[i-1];
        vs_sh_d[i]    = vs_sh_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      fcnt_q     <= '0;
      blink_q    <= 1'b0;
      blank_sh_q <= '0;
      hs_sh_q    <= '1;
      vs_sh_q    <= '1;
    end else begin
      div_q      <= div_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      fcnt_q     <= fcnt_d;
      blink_q    <= blink_d;
      blank_sh_q <= blank_sh_d;
      hs_sh_q    <= hs_sh_d;
      vs_sh_q    <= vs_sh_d;
    end
  end

  assign pixclk   = div_q;
  assign char_col = hcnt_q[9:3];
  assign char_row = vcnt_q[8:4];
  assign pix_col  = hcnt_q[2:0];
  assign pix_row  = vcnt_q[3:0];
  assign blank    = blank_sh_q[STAGES-1];
  assign hsync    = hs_sh_q[STAGES-1];
  assign vsync    = vs_sh_q[STAGES-1];
  assign blink    = blink_q;

endmodule
